// File: rtl/alu_shift_arbiter.sv
// rtl/alu_shift_arbiter.sv - round-robin arbiter sharing one alu_shift unit between requesters
//
// Purpose: grants one of NUM_REQ requesters at a time and registers its operands
//          into an external combinational shifter. One cycle later it captures the
//          shifter result and holds it as a response until the consumer accepts it.
//          Only one transaction is in flight. The sequence is IDLE -> EXEC -> RESP.
// Ports:
//   clk_i, arst_i            clock (rising edge), asynchronous active-high reset
//   req_valid_i/req_ready_o  per-requester handshake; ready is one-hot or zero
//   req_rs1_i/req_rs2_i      per-requester operands
//   req_func_t_i             per-requester func_t (shift immediate in [9:4])
//   shift_rs1_o/rs2_o/func_t_o  registered operands driven into alu_shift
//   shift_result_i           combinational alu_shift result
//   resp_valid_o/resp_ready_i   response handshake
//   resp_data_o/resp_id_o    registered result and the index of its owner
module alu_shift_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rs1_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_rs2_i,
    input  logic [NUM_REQ-1:0][15:0]             req_func_t_i,
    output logic [DATA_WIDTH-1:0]                shift_rs1_o,
    output logic [DATA_WIDTH-1:0]                shift_rs2_o,
    output logic [15:0]                          shift_func_t_o,
    input  logic [DATA_WIDTH-1:0]                shift_result_i,
    output logic                                 resp_valid_o,
    input  logic                                 resp_ready_i,
    output logic [DATA_WIDTH-1:0]                resp_data_o,
    output logic [ID_WIDTH-1:0]                  resp_id_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DATA_WIDTH-1:0]   shift_rs1_q, shift_rs1_d;
    logic [DATA_WIDTH-1:0]   shift_rs2_q, shift_rs2_d;
    logic [15:0]             shift_func_t_q, shift_func_t_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic [ID_WIDTH-1:0]     resp_id_q, resp_id_d;

    logic                    found;
    logic [ID_WIDTH-1:0]     winner;
    logic [ID_WIDTH-1:0]     cand;

    // Search starts at rr_ptr and wraps. The first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // While reset is held, ready is forced low so that no handshake appears
    // to complete.
    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && found && !arst_i) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        shift_rs1_d    = shift_rs1_q;
        shift_rs2_d    = shift_rs2_q;
        shift_func_t_d = shift_func_t_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_id_d      = resp_id_q;
        case (state_q)
            IDLE: begin
                // A valid winner has ready asserted, so found alone marks the handshake.
                if (found) begin
                    shift_rs1_d    = req_rs1_i[winner];
                    shift_rs2_d    = req_rs2_i[winner];
                    shift_func_t_d = req_func_t_i[winner];
                    id_d           = winner;
                    rr_ptr_d       = ID_WIDTH'((int'(winner) + 1) % NUM_REQ);
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = shift_result_i;
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            shift_rs1_q    <= '0;
            shift_rs2_q    <= '0;
            shift_func_t_q <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_id_q      <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            shift_rs1_q    <= shift_rs1_d;
            shift_rs2_q    <= shift_rs2_d;
            shift_func_t_q <= shift_func_t_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_id_q      <= resp_id_d;
        end
    end

    assign shift_rs1_o    = shift_rs1_q;
    assign shift_rs2_o    = shift_rs2_q;
    assign shift_func_t_o = shift_func_t_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_data_o    = resp_data_q;
    assign resp_id_o      = resp_id_q;

endmodule
